wdt: RTL and testbench
======================

WDT -- requirements
Module: wdt

Interface
REQ-001 SHALL have parameter KICK_KEY, default 16'hA5C3, the only KICK write value accepted as a valid kick.
REQ-002 SHALL have parameter CNT_W, default `XLEN, the width of the countdown counter and of the LOAD register.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port addr  in  $clog2(`WDT_SIZE)  bus byte address.
REQ-006 SHALL have bus ports w_rb (in, 1), acc (in, `BUS_ACC_WIDTH), wdata (in, `BUS_WIDTH), req (in, 1), rdata (out, `BUS_WIDTH), resp (out, 1) and fault (out, 1), with the codebase's bus semantics.
REQ-007 SHALL have port soc_fault  out  1  one-cycle pulse that drives the reset controller fault input.
REQ-008 SHALL have port soc_fault_cause  out  8  `RST_CAUSE_WDT_TMO on timeout, `RST_CAUSE_WDT_KEY on bad key.
REQ-009 SHALL have port soc_fault_addr  out  `XLEN  zero-extended count of valid kicks since the last reset.

Function
REQ-010 SHALL use this register map: CTRL @0 (2B, RW, bit0 EN, bit1 LOCK, bit2 EXPIRED read-only); KICK @2 (2B, W); LOAD @4 (4B, RW); CNT @8 (4B, R); WIN @12 (4B, RW, only when WDT_WINDOW_EN is defined).
REQ-011 SHALL assert fault combinationally as req & invalid, where invalid is any of: unmapped address, acc not matching the register size, write to CNT, or read of KICK.
REQ-012 SHALL, on every valid access (req & ~invalid), register resp high in the following cycle with rdata valid in that same cycle; resp SHALL be low otherwise.
REQ-013 SHALL decrement CNT by 1 per cycle while EN=1 and CNT!=0.
REQ-014 SHALL, on the cycle CNT changes 1->0, pulse soc_fault for exactly one cycle with cause `RST_CAUSE_WDT_TMO and set EXPIRED; CNT SHALL then hold at 0 with no further pulses.
REQ-015 SHALL treat a KICK write with wdata[15:0]==KICK_KEY as a valid kick: CNT<=LOAD, EXPIRED<=0, kick counter +1 (saturating at all-ones).
REQ-016 SHALL treat a KICK write with any other value as a bad key: one-cycle soc_fault with cause `RST_CAUSE_WDT_KEY, and CNT unchanged.
REQ-017 SHALL, when a valid kick coincides with the 1->0 transition, give the kick priority: no soc_fault is issued.
REQ-018 SHALL, on a 0->1 write of EN, load CNT<=LOAD in the same edge.
REQ-019 SHALL, on writing EN=0, freeze CNT.
REQ-020 SHALL, once LOCK=1, silently ignore writes to CTRL, LOAD and WIN (resp still returned) until reset.
REQ-021 SHALL, with LOAD==0 and EN=1, hold CNT at 0 and issue no timeout pulse.
REQ-022 SHALL, for simultaneous bad-key and timeout events in one cycle, issue one pulse with cause `RST_CAUSE_WDT_KEY.

Reset
REQ-023 SHALL, while rst is high, force EN=0, LOCK=0, EXPIRED=0, CNT=0, LOAD=all-ones, WIN=0, kick counter=0, resp=0, rdata=0, soc_fault=0, soc_fault_cause=0.
REQ-024 SHALL, when rst asserts mid-countdown, abort the countdown with no soc_fault pulse.

Configuration
REQ-025 SHALL, with WDT_WINDOW_EN defined, implement WIN and treat a key-correct kick issued while CNT > WIN as a bad key (cause `RST_CAUSE_WDT_KEY, CNT unchanged).
REQ-026 SHALL, with WDT_WINDOW_EN undefined, omit WIN: address 12 is unmapped (fault) and kicks are accepted at any CNT value.

Structure
REQ-027 SHALL define `WDT_SIZE, `RST_CAUSE_WDT_TMO, `RST_CAUSE_WDT_KEY and the register offsets in femto.vh, distinct from the existing RST cause codes.
REQ-028 SHALL be a single module with no sub-modules; its soc_fault* outputs connect directly to the reset controller's fault inputs.

Verification
REQ-029 SHALL verify timeout: LOAD=10, EN=1 -> CNT reaches 0 after 10 cycles; exactly one soc_fault pulse, cause TMO, EXPIRED=1, CNT stays 0.
REQ-030 SHALL verify kick: LOAD=10, KICK=0xA5C3 when CNT=1 -> no pulse, CNT=10, soc_fault_addr=1.
REQ-031 SHALL verify bad key: KICK=0x1234 -> one pulse, cause KEY, CNT unchanged.
REQ-032 SHALL verify lock: CTRL=0x3, then CTRL=0x0 -> resp=1, EN still 1, countdown continues.
REQ-033 SHALL verify bus faults: 4B access to CTRL, read of KICK, write of CNT, addr 6 -> fault=1, no resp, no state change.
REQ-034 SHALL verify window (WDT_WINDOW_EN): WIN=3, LOAD=10, kick at CNT=5 -> cause KEY; kick at CNT=2 -> accepted.

Source files
------------

// File: rtl/wdt_pkg.sv
// SoC-wide definitions shared with the reset controller, plus the WDT register map.
// Latency: n/a (definitions only). Backpressure: n/a. Optional window register: WDT_WINDOW_EN.
`ifndef FEMTO_VH
`define FEMTO_VH
`define XLEN               32
`define BUS_WIDTH          32
`define BUS_ACC_WIDTH      2
`define RST_CAUSE_POR      8'h01
`define RST_CAUSE_EXT      8'h02
`define RST_CAUSE_SW       8'h03
`define RST_CAUSE_WDT_TMO  8'h10
`define RST_CAUSE_WDT_KEY  8'h11
`define WDT_SIZE           16
`define WDT_CTRL_OFS       0
`define WDT_KICK_OFS       2
`define WDT_LOAD_OFS       4
`define WDT_CNT_OFS        8
`define WDT_WIN_OFS        12
`endif

package wdt_pkg;
  localparam int ADDR_W = $clog2(`WDT_SIZE);
  localparam int KCNT_W = 16;

  localparam logic [ADDR_W-1:0] CTRL_OFS = ADDR_W'(`WDT_CTRL_OFS);
  localparam logic [ADDR_W-1:0] KICK_OFS = ADDR_W'(`WDT_KICK_OFS);
  localparam logic [ADDR_W-1:0] LOAD_OFS = ADDR_W'(`WDT_LOAD_OFS);
  localparam logic [ADDR_W-1:0] CNT_OFS  = ADDR_W'(`WDT_CNT_OFS);
  localparam logic [ADDR_W-1:0] WIN_OFS  = ADDR_W'(`WDT_WIN_OFS);

  // Bus access size encoding carried on acc.
  typedef enum logic [`BUS_ACC_WIDTH-1:0] {
    ACC_1B = 2'd0,
    ACC_2B = 2'd1,
    ACC_4B = 2'd2
  } acc_e;

  typedef struct packed {
    logic expired;
    logic lock;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/wdt.sv
// Watchdog: keyed-kick countdown that pulses soc_fault on timeout or bad key (window via WDT_WINDOW_EN).
// Latency: bus resp/rdata one cycle after a valid req; fault is combinational with req.
// Backpressure: none, every valid access completes in one cycle.
module wdt
  import wdt_pkg::*;
#(
  parameter logic [15:0] KICK_KEY = 16'hA5C3,
  parameter int          CNT_W    = `XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic [`BUS_WIDTH-1:0]     rdata,
  output logic                      resp,
  output logic                      fault,
  output logic                      soc_fault,
  output logic [7:0]                soc_fault_cause,
  output logic [`XLEN-1:0]          soc_fault_addr
);
  ctrl_t               ctrl;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    load;
  logic [KCNT_W-1:0]   kick_cnt;
`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0]    win;
  logic                win_wr;
`endif
  logic                sel_ctrl, sel_kick, sel_load, sel_cnt, sel_win;
  logic                invalid, acc_ok;
  logic                ctrl_wr, load_wr, kick_wr;
  logic                in_win, kick_ok, key_evt;
  logic                en_rise, en_clr, dec, tmo_evt;
  logic [`BUS_WIDTH-1:0] rd_mux;

  always_comb begin
    sel_ctrl = (addr == CTRL_OFS);
    sel_kick = (addr == KICK_OFS);
    sel_load = (addr == LOAD_OFS);
    sel_cnt  = (addr == CNT_OFS);
`ifdef WDT_WINDOW_EN
    sel_win  = (addr == WIN_OFS);
`else
    sel_win  = 1'b0;
`endif
    invalid = 1'b1;
    if (sel_ctrl)      invalid = (acc != ACC_2B);
    else if (sel_kick) invalid = (acc != ACC_2B) || !w_rb;
    else if (sel_load) invalid = (acc != ACC_4B);
    else if (sel_cnt)  invalid = (acc != ACC_4B) || w_rb;
    else if (sel_win)  invalid = (acc != ACC_4B);
  end

  assign fault  = req & invalid;
  assign acc_ok = req & ~invalid;

  // Lock gates configuration writes only; kicks always reach the counter.
  assign ctrl_wr = acc_ok & w_rb & sel_ctrl & ~ctrl.lock;
  assign load_wr = acc_ok & w_rb & sel_load & ~ctrl.lock;
  assign kick_wr = acc_ok & w_rb & sel_kick;

`ifdef WDT_WINDOW_EN
  assign win_wr = acc_ok & w_rb & sel_win & ~ctrl.lock;
  assign in_win = (cnt <= win);
`else
  assign in_win = 1'b1;
`endif

  assign kick_ok = kick_wr & (wdata[15:0] == KICK_KEY) & in_win;
  assign key_evt = kick_wr & ~kick_ok;

  assign en_rise = ctrl_wr & wdata[0] & ~ctrl.en;
  assign en_clr  = ctrl_wr & ~wdata[0];
  assign dec     = ctrl.en & ~en_clr & (cnt != '0);
  // A kick landing on the final decrement wins over the timeout.
  assign tmo_evt = dec & (cnt == CNT_W'(1)) & ~kick_ok;

  always_comb begin
    cnt_nxt = cnt;
    if (kick_ok || en_rise) cnt_nxt = load;
    else if (dec)           cnt_nxt = cnt - CNT_W'(1);
  end

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)      rd_mux = `BUS_WIDTH'(ctrl);
    else if (sel_load) rd_mux = `BUS_WIDTH'(load);
    else if (sel_cnt)  rd_mux = `BUS_WIDTH'(cnt);
`ifdef WDT_WINDOW_EN
    else if (sel_win)  rd_mux = `BUS_WIDTH'(win);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl            <= '0;
      cnt             <= '0;
      load            <= '1;
      kick_cnt        <= '0;
      resp            <= 1'b0;
      rdata           <= '0;
      soc_fault       <= 1'b0;
      soc_fault_cause <= '0;
    end else begin
      resp      <= acc_ok;
      rdata     <= (acc_ok && !w_rb) ? rd_mux : '0;
      soc_fault <= tmo_evt | key_evt;
      if (key_evt)      soc_fault_cause <= `RST_CAUSE_WDT_KEY;
      else if (tmo_evt) soc_fault_cause <= `RST_CAUSE_WDT_TMO;
      if (ctrl_wr) begin
        ctrl.en   <= wdata[0];
        ctrl.lock <= wdata[1];
      end
      if (kick_ok)      ctrl.expired <= 1'b0;
      else if (tmo_evt) ctrl.expired <= 1'b1;
      if (load_wr) load <= wdata[CNT_W-1:0];
      cnt <= cnt_nxt;
      if (kick_ok && kick_cnt != '1) kick_cnt <= kick_cnt + KCNT_W'(1);
    end
  end

`ifdef WDT_WINDOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         win <= '0;
    else if (win_wr) win <= wdata[CNT_W-1:0];
  end
`endif

  assign soc_fault_addr = `XLEN'(kick_cnt);
endmodule

// File: tb/tb_wdt.sv
// Directed bench for the watchdog: bus map, countdown, kicks, lock, faults and reset behaviour.
module tb_wdt;
  localparam logic [7:0] TMO = 8'h10;
  localparam logic [7:0] KEY = 8'h11;
  localparam logic [3:0] A_CTRL = 4'd0, A_KICK = 4'd2, A_LOAD = 4'd4, A_CNT = 4'd8, A_WIN = 4'd12;
  localparam logic [1:0] B2 = 2'd1, B4 = 2'd2;

  logic        clk, rst, w_rb, req, resp, fault, soc_fault;
  logic [3:0]  addr;
  logic [1:0]  acc;
  logic [31:0] wdata, rdata, soc_fault_addr;
  logic [7:0]  soc_fault_cause;

  int n_chk = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic        f, r;
  logic [31:0] rd;

  wdt dut (
    .clk(clk), .rst(rst), .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
    .rdata(rdata), .resp(resp), .fault(fault), .soc_fault(soc_fault),
    .soc_fault_cause(soc_fault_cause), .soc_fault_addr(soc_fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (soc_fault === 1'b1) pulse_cnt = pulse_cnt + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle starting just after a rising edge; returns fault during req and resp/rdata after.
  task automatic bus(input logic w, input logic [3:0] a, input logic [1:0] ac, input logic [31:0] d,
                     output logic fo, output logic ro, output logic [31:0] rdo);
    w_rb = w; addr = a; acc = ac; wdata = d; req = 1'b1;
    #1 fo = fault;
    @(posedge clk); #1;
    req = 1'b0; w_rb = 1'b0; wdata = '0;
    ro = resp; rdo = rdata;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    n_chk++; if (resp !== 1'b0) begin n_err++; $display("FAIL reset_resp: got %b want 0", resp); end
    n_chk++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_chk++; if (soc_fault !== 1'b0 || soc_fault_cause !== 8'h0)
      begin n_err++; $display("FAIL reset_soc_fault: got %b/%h want 0/00", soc_fault, soc_fault_cause); end
    n_chk++; if (soc_fault_addr !== 32'h0) begin n_err++; $display("FAIL reset_kicks: got %h want 0", soc_fault_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_cnt = 0;
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (r !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got resp=%b %h want resp=1 0", r, rd); end
    bus(1'b0, A_LOAD, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_load: got %h want ffffffff", rd); end
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", rd); end
  endtask

  task automatic test_timeout();
    int seen_at = 0;
    logic [7:0] cause = 8'h0;
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd10, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (soc_fault === 1'b1 && seen_at == 0) begin seen_at = i; cause = soc_fault_cause; end
    end
    n_chk++; if (seen_at != 10) begin n_err++; $display("FAIL tmo_cycle: got %0d want 10", seen_at); end
    n_chk++; if (cause !== TMO) begin n_err++; $display("FAIL tmo_cause: got %h want %h", cause, TMO); end
    n_chk++; if (pulse_cnt != 1) begin n_err++; $display("FAIL tmo_pulses: got %0d want 1", pulse_cnt); end
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h5) begin n_err++; $display("FAIL tmo_ctrl: got %h want 5", rd); end
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h0) begin n_err++; $display("FAIL tmo_cnt: got %h want 0", rd); end
  endtask

  task automatic test_kick();
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd10, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    tick(9);
    bus(1'b1, A_KICK, B2, 32'h0000_A5C3, f, r, rd);
    n_chk++; if (soc_fault !== 1'b0) begin n_err++; $display("FAIL kick_nopulse: got %b want 0", soc_fault); end
    n_chk++; if (soc_fault_addr !== 32'd1) begin n_err++; $display("FAIL kick_count: got %h want 1", soc_fault_addr); end
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd10) begin n_err++; $display("FAIL kick_cnt: got %0d want 10", rd); end
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h1) begin n_err++; $display("FAIL kick_ctrl: got %h want 1", rd); end
    n_chk++; if (pulse_cnt != 0) begin n_err++; $display("FAIL kick_pulses: got %0d want 0", pulse_cnt); end
  endtask

  task automatic test_bad_key();
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd10, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    bus(1'b1, A_KICK, B2, 32'h0000_1234, f, r, rd);
    n_chk++; if (soc_fault !== 1'b1 || soc_fault_cause !== KEY)
      begin n_err++; $display("FAIL badkey_pulse: got %b/%h want 1/%h", soc_fault, soc_fault_cause, KEY); end
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd9) begin n_err++; $display("FAIL badkey_cnt: got %0d want 9", rd); end
    n_chk++; if (soc_fault !== 1'b0 || pulse_cnt != 1)
      begin n_err++; $display("FAIL badkey_once: got %b/%0d want 0/1", soc_fault, pulse_cnt); end
    n_chk++; if (soc_fault_addr !== 32'd0) begin n_err++; $display("FAIL badkey_kicks: got %h want 0", soc_fault_addr); end
  endtask

  task automatic test_lock();
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd20, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h3, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (r !== 1'b1 || f !== 1'b0) begin n_err++; $display("FAIL lock_resp: got resp=%b fault=%b want 1/0", r, f); end
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h3) begin n_err++; $display("FAIL lock_ctrl: got %h want 3", rd); end
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd18) begin n_err++; $display("FAIL lock_cnt: got %0d want 18", rd); end
    bus(1'b1, A_LOAD, B4, 32'd5, f, r, rd);
    bus(1'b0, A_LOAD, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd20) begin n_err++; $display("FAIL lock_load: got %0d want 20", rd); end
  endtask

  task automatic test_freeze();
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd10, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    tick(2);
    bus(1'b1, A_CTRL, B2, 32'h0, f, r, rd);
    tick(3);
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd8) begin n_err++; $display("FAIL freeze_cnt: got %0d want 8", rd); end
  endtask

  task automatic test_bus_faults();
    logic [6:0] tbl [6];
    tbl[0] = {1'b1, A_CTRL, B4};
    tbl[1] = {1'b0, A_KICK, B2};
    tbl[2] = {1'b1, A_CNT,  B4};
    tbl[3] = {1'b0, 4'd6,   B2};
    tbl[4] = {1'b1, A_LOAD, B2};
`ifdef WDT_WINDOW_EN
    tbl[5] = {1'b1, A_WIN,  B2};
`else
    tbl[5] = {1'b1, A_WIN,  B4};
`endif
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      bus(tbl[i][6], tbl[i][5:2], tbl[i][1:0], 32'h3, f, r, rd);
      n_chk++; if (f !== 1'b1 || r !== 1'b0)
        begin n_err++; $display("FAIL busfault_%0d: got fault=%b resp=%b want 1/0", i, f, r); end
    end
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h0) begin n_err++; $display("FAIL busfault_ctrl: got %h want 0", rd); end
    bus(1'b0, A_LOAD, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL busfault_load: got %h want ffffffff", rd); end
    n_chk++; if (pulse_cnt != 0) begin n_err++; $display("FAIL busfault_pulses: got %0d want 0", pulse_cnt); end
  endtask

  task automatic test_edge_cases();
    // LOAD of zero: counter parks at 0 without a timeout.
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd0, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    tick(5);
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h1 || pulse_cnt != 0)
      begin n_err++; $display("FAIL load0: got ctrl=%h pulses=%0d want 1/0", rd, pulse_cnt); end
    // Bad key on the final decrement: single pulse reporting the key cause.
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd4, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    tick(3);
    bus(1'b1, A_KICK, B2, 32'h0000_BEEF, f, r, rd);
    n_chk++; if (soc_fault !== 1'b1 || soc_fault_cause !== KEY)
      begin n_err++; $display("FAIL both_cause: got %b/%h want 1/%h", soc_fault, soc_fault_cause, KEY); end
    tick(3);
    n_chk++; if (pulse_cnt != 1) begin n_err++; $display("FAIL both_pulses: got %0d want 1", pulse_cnt); end
    // Reset mid-countdown suppresses the pending timeout.
    apply_reset();
    bus(1'b1, A_LOAD, B4, 32'd3, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    tick(1);
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(3);
    n_chk++; if (pulse_cnt != 0) begin n_err++; $display("FAIL rst_abort: got %0d pulses want 0", pulse_cnt); end
    bus(1'b0, A_CTRL, B2, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_abort_ctrl: got %h want 0", rd); end
  endtask

`ifdef WDT_WINDOW_EN
  task automatic test_window();
    apply_reset();
    bus(1'b1, A_WIN, B4, 32'd3, f, r, rd);
    bus(1'b0, A_WIN, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd3) begin n_err++; $display("FAIL win_read: got %0d want 3", rd); end
    bus(1'b1, A_LOAD, B4, 32'd10, f, r, rd);
    bus(1'b1, A_CTRL, B2, 32'h1, f, r, rd);
    tick(5);
    bus(1'b1, A_KICK, B2, 32'h0000_A5C3, f, r, rd);
    n_chk++; if (soc_fault !== 1'b1 || soc_fault_cause !== KEY)
      begin n_err++; $display("FAIL win_early: got %b/%h want 1/%h", soc_fault, soc_fault_cause, KEY); end
    tick(2);
    bus(1'b1, A_KICK, B2, 32'h0000_A5C3, f, r, rd);
    n_chk++; if (soc_fault !== 1'b0 || soc_fault_addr !== 32'd1)
      begin n_err++; $display("FAIL win_ok: got %b/%h want 0/1", soc_fault, soc_fault_addr); end
    bus(1'b0, A_CNT, B4, 32'h0, f, r, rd);
    n_chk++; if (rd !== 32'd10) begin n_err++; $display("FAIL win_cnt: got %0d want 10", rd); end
  endtask
`endif

  initial begin
    rst = 1'b0; req = 1'b0; w_rb = 1'b0; addr = '0; acc = '0; wdata = '0;
    test_reset();
    test_timeout();
    test_kick();
    test_bad_key();
    test_lock();
    test_freeze();
    test_bus_faults();
    test_edge_cases();
`ifdef WDT_WINDOW_EN
    test_window();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
